odom_pulse_queue: RTL and testbench
===================================

# odom_pulse_queue

Origin-domain pulse queue placed directly upstream of `xdom_pulse_sender`. It accepts single-cycle event pulses at the full `odom_clk_i` rate and counts them as pending. It releases them one at a time on `send_pulse_o`, which drives the sender's `odom_pulse_i`, and paces releases by the sender's `busy_o` so that no event is lost while a crossing is in flight. Overflow beyond the pending capacity is flagged, not silently dropped.

## Interface
- `CNT_W`, default 8: pending-counter width; capacity is 2^CNT_W-1 events.
- `ARM_TMO`, default 16: maximum cycles to wait for `sender_busy_i` to rise after a release; valid range 2..255.
- `odom_clk_i` in 1: sole clock; all logic on its rising edge.
- `grst_i` in 1: reset, synchronous, active-high.
- `evt_i` in 1: event pulse; each high cycle is one event.
- `sender_busy_i` in 1: `busy_o` of the downstream sender.
- `send_pulse_o` out 1: one-cycle release pulse to the sender's `odom_pulse_i`; registered.
- `pending_o` out CNT_W: events queued and not yet released; registered.
- `empty_o` out 1: `pending_o == 0`.
- `ovf_o` out 1: sticky overflow flag.
- `tmo_o` out 1: sticky flag; the sender failed to assert busy within ARM_TMO.
- `flag_clr_i` in 1: clears `ovf_o` and `tmo_o`.

## Operation
- Reset values: `send_pulse_o`=0, `pending_o`=0, `empty_o`=1, `ovf_o`=0, `tmo_o`=0, state IDLE, arm counter 0.
- Pending counter (saturating up/down):
  - +1 on `evt_i`.
  - −1 on a release (the edge at which `send_pulse_o` goes high).
  - Both in the same cycle: value unchanged.
  - At 2^CNT_W-1 with `evt_i` and no release: holds, and `ovf_o` sets.
  - The counter never decrements below 0 because a release requires a nonzero count.
- FSM states:
  - **IDLE**: if `pending_o != 0` and `sender_busy_i == 0`, then at the next edge `send_pulse_o` goes to 1, the counter decrements and the state moves to ARM. Otherwise stay.
  - **ARM**: `send_pulse_o` returns to 0 after exactly one cycle.
    - If `sender_busy_i == 1`, go to WAIT.
    - Otherwise increment the arm counter. When it reaches ARM_TMO, set `tmo_o`, go to IDLE and count the event as delivered (no retry).
  - **WAIT**: go to IDLE on the first cycle `sender_busy_i == 0`.
- The arm counter clears on entry to ARM.
- Flags:
  - `ovf_o` and `tmo_o` clear on `flag_clr_i`.
  - If a set condition and `flag_clr_i` occur in the same cycle, the set wins.
- Reset mid-operation: the queue is discarded and all outputs return to their reset values at the next edge. Any in-flight crossing belongs to the sender, which shares `grst_i`.

## Timing
- Latency, empty queue with sender idle: `evt_i` high in cycle k gives `pending_o`=1 in cycle k+1 and `send_pulse_o` high in cycle k+2.
- Release spacing: at least one cycle each of ARM and WAIT, plus the sender's busy period.
  - Next release is no earlier than 1 cycle after `sender_busy_i` falls.
- `evt_i` is accepted every cycle, in every state, including the release cycle.
- `sender_busy_i` high while in IDLE blocks release. This covers a crossing started before reset release or by another source.
- `empty_o` and `pending_o` change only on clock edges. `empty_o` is combinational from the `pending_o` register.

## Structure
- Package `odom_pulse_pkg`:
  - state enum: IDLE=2'd0, ARM=2'd1, WAIT=2'd2.
  - default localparams for CNT_W and ARM_TMO.
- Sub-module `sat_updown_cnt`:
  - parameter W; inputs `inc`, `dec`, `clr`; outputs `cnt`, `sat_hit`.
  - Holds the saturation and simultaneous-event logic.
- The FSM, arm counter and flags live in the top level.
- Bench: instantiate this block with the real `xdom_pulse_sender`. Use `odom_clk_i` at 10 ns and the sender's destination clock at 100 ns.

## Test plan
- **Single event**: reset, then one `evt_i` pulse → `send_pulse_o` high exactly 2 cycles later for 1 cycle; `pending_o` goes 1 then 0; exactly one `xdom_pulse_o` downstream.
- **Burst**: 5 consecutive `evt_i` cycles → `pending_o` peaks at 4 or 5 and exactly 5 `send_pulse_o` pulses occur. Each pulse is issued only after `sender_busy_i` has fallen. Exactly 5 `xdom_pulse_o` downstream.
- **Simultaneous event and release**: `evt_i` high on the release cycle with `pending_o`=1 → `pending_o` stays 1 and a second release follows after busy falls.
- **Overflow**: with CNT_W=3 and `sender_busy_i` forced high, send 9 events → `pending_o`=7 and `ovf_o`=1. Pulse `flag_clr_i` in the same cycle as a 10th event → `ovf_o` stays 1.
- **Timeout**: `sender_busy_i` tied low, one event → `tmo_o` sets after ARM_TMO cycles in ARM; state returns to IDLE; `pending_o`=0.
- **Reset mid-flight**: 3 events queued, assert `grst_i` during WAIT for one cycle → next cycle `pending_o`=0, `send_pulse_o`=0, `empty_o`=1, both flags 0; no further releases.

Source files
------------

// File: rtl/odom_pulse_pkg.sv
// Shared types and default parameters for the origin-domain pulse queue.
`timescale 1ns/1ps
package odom_pulse_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int CNT_W_DEF   = 8;
    localparam int ARM_TMO_DEF = 16;
endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter. Simultaneous inc and dec cancel; sat_hit flags an inc lost at full scale.
`timescale 1ns/1ps
module sat_updown_cnt #(
    parameter int W = 8
) (
    input  logic         odom_clk_i,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat_hit
);
    localparam logic [W-1:0] CNT_MAX = '1;

    assign sat_hit = inc && !dec && (cnt == CNT_MAX);

    always_ff @(posedge odom_clk_i) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - W'(1);
        end
    end
endmodule

// File: rtl/odom_pulse_queue.sv
// Queues origin-domain event pulses and releases them one at a time,
// paced by the downstream crossing sender's busy signal.
//
// state | meaning
// IDLE  | no crossing in flight; release when events pending and sender idle
// ARM   | release pulse out, waiting for sender busy to rise (bounded)
// WAIT  | sender busy; return to IDLE when it drops
`timescale 1ns/1ps
module odom_pulse_queue
    import odom_pulse_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ARM_TMO = ARM_TMO_DEF
) (
    input  logic             odom_clk_i,
    input  logic             grst_i,
    input  logic             evt_i,
    input  logic             sender_busy_i,
    input  logic             flag_clr_i,
    output logic             send_pulse_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             tmo_o
);
    localparam logic [7:0] TMO_VAL = 8'(ARM_TMO);

    state_t     state_q, state_d;
    logic [7:0] arm_q, arm_d;
    logic       release_c;
    logic       tmo_set;
    logic       sat_hit;

    sat_updown_cnt #(.W(CNT_W)) u_cnt (
        .odom_clk_i (odom_clk_i),
        .clr        (grst_i),
        .inc        (evt_i),
        .dec        (release_c),
        .cnt        (pending_o),
        .sat_hit    (sat_hit)
    );

    assign empty_o = (pending_o == '0);

    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        release_c = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_o && !sender_busy_i) begin
                    release_c = 1'b1;
                    arm_d     = '0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (sender_busy_i) begin
                    state_d = WAIT;
                end else begin
                    arm_d = arm_q + 8'd1;
                    // Sender never acknowledged: drop the event rather than retry.
                    if (arm_d == TMO_VAL) begin
                        tmo_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (!sender_busy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge odom_clk_i) begin
        if (grst_i) begin
            state_q      <= IDLE;
            arm_q        <= '0;
            send_pulse_o <= 1'b0;
            ovf_o        <= 1'b0;
            tmo_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            send_pulse_o <= release_c;
            // Set beats clear when both land in the same cycle.
            if (sat_hit)         ovf_o <= 1'b1;
            else if (flag_clr_i) ovf_o <= 1'b0;
            if (tmo_set)         tmo_o <= 1'b1;
            else if (flag_clr_i) tmo_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_odom_pulse_queue.sv
// Directed bench for odom_pulse_queue with a behavioural crossing sender model.
`timescale 1ns/1ps
module tb_odom_pulse_queue;
    import odom_pulse_pkg::*;

    logic       odom_clk_i = 1'b0;
    logic       dst_clk    = 1'b0;
    logic       grst_i     = 1'b1;
    logic       evt_i      = 1'b0;
    logic       flag_clr_i = 1'b0;
    logic       sender_busy;
    logic       send_pulse_o, empty_o, ovf_o, tmo_o;
    logic [7:0] pending_o;

    logic       evt2 = 1'b0, clr2 = 1'b0, busy2 = 1'b1;
    logic       send2, empty2, ovf2, tmo2;
    logic [2:0] pend2;

    int compared   = 0;
    int mismatched = 0;
    int busy_mode  = 0;
    int send_cnt   = 0;
    int xdom_cnt   = 0;
    int viol       = 0;

    logic m_req = 1'b0, m_busy = 1'b0, m_ack_s1 = 1'b0, m_ack_s2 = 1'b0;
    logic d_r1 = 1'b0, d_r2 = 1'b0, d_r3 = 1'b0, d_ack = 1'b0;
    logic m_pulse;

    always #5  odom_clk_i = ~odom_clk_i;
    always #50 dst_clk    = ~dst_clk;

    assign sender_busy = (busy_mode == 0) ? m_busy : 1'b0;
    assign m_pulse     = (busy_mode == 0) && send_pulse_o;

    odom_pulse_queue dut (
        .odom_clk_i    (odom_clk_i),
        .grst_i        (grst_i),
        .evt_i         (evt_i),
        .sender_busy_i (sender_busy),
        .flag_clr_i    (flag_clr_i),
        .send_pulse_o  (send_pulse_o),
        .pending_o     (pending_o),
        .empty_o       (empty_o),
        .ovf_o         (ovf_o),
        .tmo_o         (tmo_o)
    );

    odom_pulse_queue #(.CNT_W(3), .ARM_TMO(16)) dut_s (
        .odom_clk_i    (odom_clk_i),
        .grst_i        (grst_i),
        .evt_i         (evt2),
        .sender_busy_i (busy2),
        .flag_clr_i    (clr2),
        .send_pulse_o  (send2),
        .pending_o     (pend2),
        .empty_o       (empty2),
        .ovf_o         (ovf2),
        .tmo_o         (tmo2)
    );

    // Sender model: toggle request, 2-flop sync each way, busy until ack returns.
    always @(posedge odom_clk_i) begin
        if (grst_i) begin
            m_req <= 1'b0; m_busy <= 1'b0; m_ack_s1 <= 1'b0; m_ack_s2 <= 1'b0;
        end else begin
            m_ack_s1 <= d_ack;
            m_ack_s2 <= m_ack_s1;
            if (m_pulse && !m_busy) begin
                m_req  <= ~m_req;
                m_busy <= 1'b1;
            end else if (m_busy && (m_ack_s2 == m_req)) begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(posedge dst_clk or posedge grst_i) begin
        if (grst_i) begin
            d_r1 <= 1'b0; d_r2 <= 1'b0; d_r3 <= 1'b0; d_ack <= 1'b0;
        end else begin
            d_r1  <= m_req;
            d_r2  <= d_r1;
            d_r3  <= d_r2;
            d_ack <= d_r2;
        end
    end

    always @(posedge dst_clk) begin
        if (!grst_i && (d_r2 ^ d_r3)) xdom_cnt++;
    end

    always @(posedge odom_clk_i) begin
        if (send_pulse_o) send_cnt++;
        if (send_pulse_o && sender_busy) viol++;
    end

    task automatic tick();
        @(negedge odom_clk_i);
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (dut.state_q == IDLE && !m_busy && pending_o == 8'd0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_reset();
        grst_i = 1'b1;
        repeat (30) tick();
        grst_i = 1'b0;
        compared++; if (send_pulse_o !== 1'b0) begin mismatched++; $display("FAIL rst_send: got %b want 0", send_pulse_o); end
        compared++; if (pending_o !== 8'd0) begin mismatched++; $display("FAIL rst_pending: got %0d want 0", pending_o); end
        compared++; if (empty_o !== 1'b1) begin mismatched++; $display("FAIL rst_empty: got %b want 1", empty_o); end
        compared++; if (ovf_o !== 1'b0 || tmo_o !== 1'b0) begin mismatched++; $display("FAIL rst_flags: got ovf=%b tmo=%b want 0/0", ovf_o, tmo_o); end
        compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
        compared++; if (pend2 !== 3'd0 || empty2 !== 1'b1) begin mismatched++; $display("FAIL rst_small: got pend=%0d empty=%b want 0/1", pend2, empty2); end
    endtask

    task automatic test_single();
        int bs, bx;
        bit ok;
        bs = send_cnt; bx = xdom_cnt;
        evt_i = 1'b1; tick(); evt_i = 1'b0;
        compared++; if (pending_o !== 8'd1 || send_pulse_o !== 1'b0) begin mismatched++; $display("FAIL single_k1: got pend=%0d send=%b want 1/0", pending_o, send_pulse_o); end
        tick();
        compared++; if (pending_o !== 8'd0 || send_pulse_o !== 1'b1) begin mismatched++; $display("FAIL single_k2: got pend=%0d send=%b want 0/1", pending_o, send_pulse_o); end
        tick();
        compared++; if (send_pulse_o !== 1'b0) begin mismatched++; $display("FAIL single_k3: got send=%b want 0", send_pulse_o); end
        wait_quiet(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL single_quiet: got timeout want idle"); end
        compared++; if (send_cnt - bs !== 1) begin mismatched++; $display("FAIL single_releases: got %0d want 1", send_cnt - bs); end
        compared++; if (xdom_cnt - bx !== 1) begin mismatched++; $display("FAIL single_xdom: got %0d want 1", xdom_cnt - bx); end
    endtask

    task automatic test_burst();
        int bs, bx, peak;
        bit ok;
        bs = send_cnt; bx = xdom_cnt; peak = 0;
        for (int i = 0; i < 5; i++) begin
            evt_i = 1'b1; tick();
            if (int'(pending_o) > peak) peak = int'(pending_o);
        end
        evt_i = 1'b0;
        wait_quiet(ok);
        compared++; if (peak !== 4) begin mismatched++; $display("FAIL burst_peak: got %0d want 4", peak); end
        compared++; if (!ok) begin mismatched++; $display("FAIL burst_quiet: got timeout want idle"); end
        compared++; if (send_cnt - bs !== 5) begin mismatched++; $display("FAIL burst_releases: got %0d want 5", send_cnt - bs); end
        compared++; if (xdom_cnt - bx !== 5) begin mismatched++; $display("FAIL burst_xdom: got %0d want 5", xdom_cnt - bx); end
        compared++; if (viol !== 0) begin mismatched++; $display("FAIL burst_busy_release: got %0d want 0", viol); end
    endtask

    task automatic test_back_to_back();
        int bs, bx;
        bit ok;
        bs = send_cnt; bx = xdom_cnt;
        evt_i = 1'b1; tick();
        tick(); evt_i = 1'b0;
        compared++; if (pending_o !== 8'd1 || send_pulse_o !== 1'b1) begin mismatched++; $display("FAIL simul_hold: got pend=%0d send=%b want 1/1", pending_o, send_pulse_o); end
        wait_quiet(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL simul_quiet: got timeout want idle"); end
        compared++; if (send_cnt - bs !== 2 || xdom_cnt - bx !== 2) begin mismatched++; $display("FAIL simul_count: got rel=%0d xdom=%0d want 2/2", send_cnt - bs, xdom_cnt - bx); end
        compared++; if (viol !== 0) begin mismatched++; $display("FAIL simul_busy_release: got %0d want 0", viol); end
    endtask

    task automatic test_timeout();
        busy_mode = 1;
        tick();
        evt_i = 1'b1; tick(); evt_i = 1'b0;
        tick();
        compared++; if (send_pulse_o !== 1'b1 || dut.state_q !== ARM) begin mismatched++; $display("FAIL tmo_release: got send=%b state=%0d want 1/1", send_pulse_o, dut.state_q); end
        repeat (15) tick();
        compared++; if (tmo_o !== 1'b0 || dut.state_q !== ARM) begin mismatched++; $display("FAIL tmo_early: got tmo=%b state=%0d want 0/1", tmo_o, dut.state_q); end
        tick();
        compared++; if (tmo_o !== 1'b1 || dut.state_q !== IDLE) begin mismatched++; $display("FAIL tmo_fire: got tmo=%b state=%0d want 1/0", tmo_o, dut.state_q); end
        compared++; if (pending_o !== 8'd0) begin mismatched++; $display("FAIL tmo_pending: got %0d want 0", pending_o); end
        flag_clr_i = 1'b1; tick(); flag_clr_i = 1'b0;
        compared++; if (tmo_o !== 1'b0) begin mismatched++; $display("FAIL tmo_clear: got %b want 0", tmo_o); end
        busy_mode = 0;
        repeat (5) tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) begin evt2 = 1'b1; tick(); end
        evt2 = 1'b0;
        compared++; if (pend2 !== 3'd7 || ovf2 !== 1'b0) begin mismatched++; $display("FAIL ovf_full: got pend=%0d ovf=%b want 7/0", pend2, ovf2); end
        for (int i = 0; i < 2; i++) begin evt2 = 1'b1; tick(); end
        evt2 = 1'b0;
        compared++; if (pend2 !== 3'd7 || ovf2 !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got pend=%0d ovf=%b want 7/1", pend2, ovf2); end
        evt2 = 1'b1; clr2 = 1'b1; tick(); evt2 = 1'b0; clr2 = 1'b0;
        compared++; if (ovf2 !== 1'b1 || pend2 !== 3'd7) begin mismatched++; $display("FAIL ovf_set_wins: got ovf=%b pend=%0d want 1/7", ovf2, pend2); end
        clr2 = 1'b1; tick(); clr2 = 1'b0;
        compared++; if (ovf2 !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b want 0", ovf2); end
        evt2 = 1'b1; tick(); evt2 = 1'b0;
        compared++; if (ovf2 !== 1'b1 || send2 !== 1'b0) begin mismatched++; $display("FAIL ovf_reset_again: got ovf=%b send=%b want 1/0", ovf2, send2); end
    endtask

    task automatic test_midflight_reset();
        int bs;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin evt_i = 1'b1; tick(); end
        evt_i = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dut.state_q == WAIT) begin hit = 1'b1; break; end
            tick();
        end
        compared++; if (!hit || pending_o !== 8'd2) begin mismatched++; $display("FAIL mid_wait: got reached=%b pend=%0d want 1/2", hit, pending_o); end
        grst_i = 1'b1; tick(); grst_i = 1'b0;
        compared++; if (pending_o !== 8'd0 || send_pulse_o !== 1'b0 || empty_o !== 1'b1) begin mismatched++; $display("FAIL mid_outputs: got pend=%0d send=%b empty=%b want 0/0/1", pending_o, send_pulse_o, empty_o); end
        compared++; if (ovf_o !== 1'b0 || tmo_o !== 1'b0 || ovf2 !== 1'b0 || pend2 !== 3'd0) begin mismatched++; $display("FAIL mid_flags: got ovf=%b tmo=%b ovf2=%b pend2=%0d want 0/0/0/0", ovf_o, tmo_o, ovf2, pend2); end
        bs = send_cnt;
        repeat (100) tick();
        compared++; if (send_cnt !== bs) begin mismatched++; $display("FAIL mid_no_release: got %0d want %0d", send_cnt, bs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_midflight_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion want finish by 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
